kdtree_load_ctrl: RTL
=====================

# kdtree_load_ctrl

Sequencer between the input FIFO read side and the accelerator's storage. After a `load_kdtree` pulse it consumes the 11-bit input word stream and routes it in a fixed order: internal nodes to the node table, leaf patches to leaf memory, then query patches to query memory. Multi-word records are assembled into single wide writes. It raises `load_done` so the top-level FSM can accept `fsm_start`.

## Interface
Parameters:
- `DATA_WIDTH`, 11: input word width.
- `PATCH_SIZE`, 5: data words per patch.
- `LEAF_SIZE`, 8: patches per leaf.
- `NUM_LEAVES`, 64: leaf count; `NUM_NODES = NUM_LEAVES-1`.
- `NUM_QUERYS`, 494: query patch count (26×19).
- `QADDR_WIDTH`, `$clog2(NUM_QUERYS)` = 9.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous active-low reset; one clock, async active-low reset.
- `load_kdtree` in 1: single-cycle start pulse.
- `in_fifo_rdata` in `DATA_WIDTH`: show-ahead FIFO head word.
- `in_fifo_rempty_n` in 1: head word valid.
- `in_fifo_deq` out 1: pop head this cycle.
- `node_wen` out 1: node table write strobe.
- `node_waddr` out 6: node number.
- `node_idx` out `DATA_WIDTH`: split dimension.
- `node_median` out `DATA_WIDTH`: split value.
- `leaf_wen` out 1: leaf memory write strobe.
- `leaf_waddr` out 6: leaf number.
- `leaf_slot` out 3: patch within leaf.
- `leaf_wpatch` out `PATCH_SIZE*DATA_WIDTH`: word 0 in the LSBs.
- `leaf_wpidx` out `DATA_WIDTH`: original image patch index.
- `query_wen` out 1: query memory write strobe.
- `query_waddr` out `QADDR_WIDTH`.
- `query_wpatch` out `PATCH_SIZE*DATA_WIDTH`.
- `busy` out 1: high in NODES, LEAVES or QUERIES.
- `load_done` out 1: all records written.

## Operation
- States: IDLE, NODES, LEAVES, QUERIES, DONE.
- IDLE/DONE --`load_kdtree`--> NODES. All counters and the assembler clear, and `load_done` drops.
- In a load state, `in_fifo_deq = in_fifo_rempty_n`. One word is consumed per cycle in which it is high. Bubbles stall the counters only.
- NODES: 2 words per node, in the order index then median. The median word triggers the node write, and `node_waddr` increments 0..62. After node 62 the state goes to LEAVES.
- LEAVES: 6 words per patch, in the order 5 data words then pidx. The pidx word triggers the leaf write. `leaf_slot` counts 0..7 and then wraps, incrementing `leaf_waddr`. After leaf 63 slot 7 the state goes to QUERIES (64×48 = 3072 words).
- QUERIES: 5 words per patch. The 5th word triggers the query write, and `query_waddr` counts 0..493. After the 494th write the state goes to DONE.
- DONE: `load_done`=1 and `in_fifo_deq`=0 until the next `load_kdtree`.
- `load_kdtree` while busy aborts the load and restarts at NODES node 0. Any write strobe due that cycle is suppressed.
- FIFO words arriving in IDLE/DONE are left in the FIFO and are not popped.

## Timing
- Reset values: all strobes 0, addresses/data 0, `busy` 0, `load_done` 0, state IDLE.
- Write strobes are registered and pulse for 1 cycle, the cycle after the completing word is dequeued. Address and data are stable in the same cycle as the strobe.
- `busy` rises the cycle after `load_kdtree`.
- `load_done` rises the cycle after the final query strobe, which is 2 cycles after the last word is dequeued.
- Minimum load time is 126 + 3072 + 2470 = 5668 consuming cycles.
- Counter widths are exact: node 6b, slot 3b, leaf 6b, word 3b, query 9b. The terminal compares (62, 7/63, 4 or 5, 493) must not rely on overflow.

## Structure
- Shared package `kdtree_load_pkg`:
  - state enum `load_state_e`
  - constants `NODE_WORDS=2`, `LEAF_REC_WORDS=PATCH_SIZE+1`, `NUM_NODES`
  - packed patch type `patch_t`
- Sub-module `patch_assembler`: word counter plus a 5-entry shift register. It has clear, push and full outputs and is shared by LEAVES and QUERIES.

## Test plan
- Reset mid-stream: assert `rst_n`=0 during LEAVES → all outputs 0 immediately. After release, no strobes until `load_kdtree`.
- Full load with continuous FIFO: 63 `node_wen` pulses, with node 0 carrying the first two file words. Then 512 `leaf_wen` pulses, with the last at waddr 63 / slot 7. Then 494 `query_wen` pulses, the last at waddr 493. `load_done` rises exactly 2 cycles after the 5668th dequeue.
- Random `in_fifo_rempty_n` bubbles (50%): same write contents and counts as the continuous case, and `in_fifo_deq` never asserted while `in_fifo_rempty_n`=0.
- Packing: leaf record words 1,2,3,4,5 then pidx 300 → `leaf_wpatch` = {5,4,3,2,1} (word 0 in LSBs) and `leaf_wpidx`=300.
- Restart: `load_kdtree` pulsed at query 100 → next node write is at addr 0 with fresh data, and there is no stray query write.
- Idle hold: FIFO non-empty in DONE → `in_fifo_deq` stays 0 for 100 cycles and `load_done` stays 1.

Source files
------------

// File: rtl/kdtree_load_pkg.sv
// Shared types and constants for the kd-tree load sequencer: state encoding,
// record word counts and the packed patch type.
package kdtree_load_pkg;

   localparam int DEF_DATA_WIDTH = 11;
   localparam int DEF_PATCH_SIZE = 5;
   localparam int DEF_LEAF_SIZE  = 8;
   localparam int DEF_NUM_LEAVES = 64;
   localparam int DEF_NUM_QUERYS = 494;

   localparam int NUM_NODES      = DEF_NUM_LEAVES - 1;
   localparam int NODE_WORDS     = 2;
   localparam int LEAF_REC_WORDS = DEF_PATCH_SIZE + 1;

   typedef logic [DEF_PATCH_SIZE*DEF_DATA_WIDTH-1:0] patch_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NODES,
      S_LEAVES,
      S_QUERIES,
      S_DONE
   } load_state_e;

endpackage

// File: rtl/kdtree_load_ctrl_patch_assembler.sv
// Collects PATCH_SIZE words into one wide patch, word 0 ending in the LSBs.
// patch_next is the patch as it would look with din shifted in this cycle.
module patch_assembler #(
   parameter int DATA_WIDTH = 11,
   parameter int PATCH_SIZE = 5
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic                             push,
   input  logic [DATA_WIDTH-1:0]            din,
   output logic                             full,
   output logic                             last,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_next
);

   localparam int PW = PATCH_SIZE * DATA_WIDTH;
   localparam int WC = $clog2(PATCH_SIZE + 1);

   logic [WC-1:0] word_cnt;
   logic [PW-1:0] shreg;

   // New words enter at the top, so after PATCH_SIZE pushes word 0 sits in the LSBs.
   assign patch_next = {din, shreg[PW-1:DATA_WIDTH]};
   assign patch      = shreg;
   assign full       = (word_cnt == WC'(PATCH_SIZE));
   assign last       = (word_cnt == WC'(PATCH_SIZE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         shreg    <= '0;
      end else if (clear) begin
         word_cnt <= '0;
         shreg    <= '0;
      end else if (push && !full) begin
         word_cnt <= word_cnt + 1'b1;
         shreg    <= patch_next;
      end
   end

endmodule

// File: rtl/kdtree_load_ctrl.sv
// Routes the input word stream into node table, leaf memory and query memory
// after a load_kdtree pulse, then flags load_done.
//
// state     | meaning
// S_IDLE    | waiting for first load_kdtree, FIFO untouched
// S_NODES   | index/median pairs -> node table
// S_LEAVES  | 5 data words + pidx -> leaf memory
// S_QUERIES | 5 data words -> query memory
// S_DONE    | all records written, load_done high, FIFO untouched
module kdtree_load_ctrl
   import kdtree_load_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int PATCH_SIZE  = DEF_PATCH_SIZE,
   parameter int LEAF_SIZE   = DEF_LEAF_SIZE,
   parameter int NUM_LEAVES  = DEF_NUM_LEAVES,
   parameter int NUM_QUERYS  = DEF_NUM_QUERYS,
   parameter int QADDR_WIDTH = $clog2(NUM_QUERYS)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                load_kdtree,
   input  logic [DATA_WIDTH-1:0]               in_fifo_rdata,
   input  logic                                in_fifo_rempty_n,
   output logic                                in_fifo_deq,
   output logic                                node_wen,
   output logic [$clog2(NUM_LEAVES-1)-1:0]     node_waddr,
   output logic [DATA_WIDTH-1:0]               node_idx,
   output logic [DATA_WIDTH-1:0]               node_median,
   output logic                                leaf_wen,
   output logic [$clog2(NUM_LEAVES)-1:0]       leaf_waddr,
   output logic [$clog2(LEAF_SIZE)-1:0]        leaf_slot,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0]    leaf_wpatch,
   output logic [DATA_WIDTH-1:0]               leaf_wpidx,
   output logic                                query_wen,
   output logic [QADDR_WIDTH-1:0]              query_waddr,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0]    query_wpatch,
   output logic                                busy,
   output logic                                load_done
);

   localparam int NODE_AW = $clog2(NUM_LEAVES - 1);
   localparam int LEAF_AW = $clog2(NUM_LEAVES);
   localparam int SLOT_W  = $clog2(LEAF_SIZE);
   localparam int PW      = PATCH_SIZE * DATA_WIDTH;

   localparam logic [NODE_AW-1:0]     NODE_LAST  = NODE_AW'(NUM_LEAVES - 2);
   localparam logic [LEAF_AW-1:0]     LEAF_LAST  = LEAF_AW'(NUM_LEAVES - 1);
   localparam logic [SLOT_W-1:0]      SLOT_LAST  = SLOT_W'(LEAF_SIZE - 1);
   localparam logic [QADDR_WIDTH-1:0] QUERY_LAST = QADDR_WIDTH'(NUM_QUERYS - 1);
   localparam logic                   NODE_WLAST = 1'(NODE_WORDS - 1);

   load_state_e            state;
   logic [NODE_AW-1:0]     node_cnt;
   logic                   node_word;
   logic [DATA_WIDTH-1:0]  idx_hold;
   logic [SLOT_W-1:0]      slot_cnt;
   logic [LEAF_AW-1:0]     leaf_cnt;
   logic [QADDR_WIDTH-1:0] query_cnt;

   logic          in_load;
   logic          asm_push;
   logic          asm_clear;
   logic          asm_full;
   logic          asm_last;
   logic [PW-1:0] asm_patch;
   logic [PW-1:0] asm_patch_next;

   assign in_load     = (state == S_NODES) || (state == S_LEAVES) || (state == S_QUERIES);
   assign busy        = in_load;
   assign in_fifo_deq = in_load && in_fifo_rempty_n;

   // In LEAVES the word after a full patch is the pidx and must not enter the shift register.
   assign asm_push  = in_fifo_deq && !load_kdtree &&
                      (((state == S_LEAVES) && !asm_full) || (state == S_QUERIES));
   assign asm_clear = load_kdtree ||
                      (in_fifo_deq && (((state == S_LEAVES) && asm_full) ||
                                       ((state == S_QUERIES) && asm_last)));

   patch_assembler #(
      .DATA_WIDTH (DATA_WIDTH),
      .PATCH_SIZE (PATCH_SIZE)
   ) u_patch_assembler (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (asm_clear),
      .push       (asm_push),
      .din        (in_fifo_rdata),
      .full       (asm_full),
      .last       (asm_last),
      .patch      (asm_patch),
      .patch_next (asm_patch_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         node_cnt     <= '0;
         node_word    <= 1'b0;
         idx_hold     <= '0;
         slot_cnt     <= '0;
         leaf_cnt     <= '0;
         query_cnt    <= '0;
         node_wen     <= 1'b0;
         node_waddr   <= '0;
         node_idx     <= '0;
         node_median  <= '0;
         leaf_wen     <= 1'b0;
         leaf_waddr   <= '0;
         leaf_slot    <= '0;
         leaf_wpatch  <= '0;
         leaf_wpidx   <= '0;
         query_wen    <= 1'b0;
         query_waddr  <= '0;
         query_wpatch <= '0;
         load_done    <= 1'b0;
      end else begin
         node_wen  <= 1'b0;
         leaf_wen  <= 1'b0;
         query_wen <= 1'b0;
         // Lags the DONE entry by one cycle so it follows the final query strobe.
         load_done <= (state == S_DONE);

         if (load_kdtree) begin
            state     <= S_NODES;
            node_cnt  <= '0;
            node_word <= 1'b0;
            slot_cnt  <= '0;
            leaf_cnt  <= '0;
            query_cnt <= '0;
            load_done <= 1'b0;
         end else if (in_fifo_deq) begin
            case (state)
               S_NODES: begin
                  if (node_word == NODE_WLAST) begin
                     node_wen    <= 1'b1;
                     node_waddr  <= node_cnt;
                     node_idx    <= idx_hold;
                     node_median <= in_fifo_rdata;
                     node_word   <= 1'b0;
                     if (node_cnt == NODE_LAST) begin
                        node_cnt <= '0;
                        state    <= S_LEAVES;
                     end else begin
                        node_cnt <= node_cnt + 1'b1;
                     end
                  end else begin
                     idx_hold  <= in_fifo_rdata;
                     node_word <= 1'b1;
                  end
               end
               S_LEAVES: begin
                  if (asm_full) begin
                     leaf_wen    <= 1'b1;
                     leaf_waddr  <= leaf_cnt;
                     leaf_slot   <= slot_cnt;
                     leaf_wpatch <= asm_patch;
                     leaf_wpidx  <= in_fifo_rdata;
                     if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (leaf_cnt == LEAF_LAST) begin
                           leaf_cnt <= '0;
                           state    <= S_QUERIES;
                        end else begin
                           leaf_cnt <= leaf_cnt + 1'b1;
                        end
                     end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                     end
                  end
               end
               S_QUERIES: begin
                  if (asm_last) begin
                     query_wen    <= 1'b1;
                     query_waddr  <= query_cnt;
                     query_wpatch <= asm_patch_next;
                     if (query_cnt == QUERY_LAST) begin
                        query_cnt <= '0;
                        state     <= S_DONE;
                     end else begin
                        query_cnt <= query_cnt + 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
